common_ram_port_arbiter: RTL and testbench

COMMON_RAM_PORT_ARBITER -- requirements
Module: common_ram_port_arbiter

---
 rtl/common_ram_arb_pkg.sv | 18 +
 rtl/common_ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_common_ram_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/common_ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: requester IDs,
// legal read latencies, and the round-robin helper.
package common_ram_arb_pkg;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // RAM read latency without / with the RAM output register.
    localparam int RD_LATENCY_NO_OREG = 1;
    localparam int RD_LATENCY_OREG    = 2;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/common_ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between two requesters;
// read responses are routed back with a tag pipeline matched to the RAM latency.
module common_ram_port_arbiter
    import common_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = RD_LATENCY_NO_OREG
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // The last tag stage lines up with the cycle ram_dout carries the read word.
    localparam int TAG_DEPTH = RD_LATENCY + 1;

    req_id_e               rr_ptr;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    req_id_e               grant_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [TAG_DEPTH-1:0]  tag_valid;
    req_id_e               tag_id [TAG_DEPTH];

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = (rr_ptr == REQ0);
                grant1 = (rr_ptr == REQ1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        accept    = grant0 | grant1;
        grant_id  = grant1 ? REQ1 : REQ0;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= REQ0;
        end else if (accept) begin
            rr_ptr <= other_req(grant_id);
        end
    end

    // Address and write data hold between accesses; only the write strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_we <= accept & sel_we;
            if (accept) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_id[i] <= REQ0;
            end
        end else begin
            tag_valid <= {tag_valid[TAG_DEPTH-2:0], accept & ~sel_we};
            tag_id[0] <= grant_id;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign req0_rvalid = tag_valid[TAG_DEPTH-1] && (tag_id[TAG_DEPTH-1] == REQ0);
    assign req1_rvalid = tag_valid[TAG_DEPTH-1] && (tag_id[TAG_DEPTH-1] == REQ1);
    assign req0_rdata  = ram_dout;
    assign req1_rdata  = ram_dout;

endmodule

// File: tb/tb_common_ram_port_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) share one stimulus stream,
// each backed by a READ_FIRST RAM model.
module tb_common_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, we0, v1, we1;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;

    logic       a_ready0, a_ready1, a_rvalid0, a_rvalid1, a_ram_we;
    logic [7:0] a_rdata0, a_rdata1, a_ram_din, a_ram_dout;
    logic [8:0] a_ram_addr;
    logic       b_ready0, b_ready1, b_rvalid0, b_rvalid1, b_ram_we;
    logic [7:0] b_rdata0, b_rdata1, b_ram_din, b_ram_dout;
    logic [8:0] b_ram_addr;

    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];
    logic [7:0] b_ram_q;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    common_ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(a_ready0), .req0_we(we0), .req0_addr(a0),
        .req0_wdata(d0), .req0_rvalid(a_rvalid0), .req0_rdata(a_rdata0),
        .req1_valid(v1), .req1_ready(a_ready1), .req1_we(we1), .req1_addr(a1),
        .req1_wdata(d1), .req1_rvalid(a_rvalid1), .req1_rdata(a_rdata1),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_dout(a_ram_dout)
    );

    common_ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(b_ready0), .req0_we(we0), .req0_addr(a0),
        .req0_wdata(d0), .req0_rvalid(b_rvalid0), .req0_rdata(b_rdata0),
        .req1_valid(v1), .req1_ready(b_ready1), .req1_we(we1), .req1_addr(a1),
        .req1_wdata(d1), .req1_rvalid(b_rvalid1), .req1_rdata(b_rdata1),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // READ_FIRST RAM models: the read samples the array before the same-edge write.
    always @(posedge clk) begin
        a_ram_dout <= mem_a[a_ram_addr];
        if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
    end

    always @(posedge clk) begin
        b_ram_q    <= mem_b[b_ram_addr];
        b_ram_dout <= b_ram_q;
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
    end

    task automatic applyStimulus(input logic v0_i, input logic we0_i, input logic [8:0] a0_i,
                                 input logic [7:0] d0_i, input logic v1_i, input logic we1_i,
                                 input logic [8:0] a1_i, input logic [7:0] d1_i);
        @(posedge clk);
        #1;
        v0 = v0_i; we0 = we0_i; a0 = a0_i; d0 = d0_i;
        v1 = v1_i; we1 = we1_i; a1 = a1_i; d1 = d1_i;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b1; we0 = 1'b0; a0 = 9'h000; d0 = 8'h00;
        v1 = 1'b0; we1 = 1'b0; a1 = 9'h000; d1 = 8'h00;
        #2;
        checkOutput("rst_ready0", a_ready0, 0);
        checkOutput("rst_ram_we", a_ram_we, 0);
        checkOutput("rst_ram_addr", a_ram_addr, 0);
        checkOutput("rst_ram_din", a_ram_din, 0);
        checkOutput("rst_rvalid", {a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}, 0);
        idle();
        rst = 1'b0;

        // Write then read 0x010 from req0, req1 write 0x1FF then req0 reads it.
        applyStimulus(1, 1, 9'h010, 8'hA5, 0, 0, 9'h000, 8'h00);            // cycle 1
        checkOutput("c1_ready0", a_ready0, 1);
        checkOutput("c1_ready1", a_ready1, 0);
        applyStimulus(1, 0, 9'h010, 8'h00, 0, 0, 9'h000, 8'h00);            // cycle 2
        checkOutput("c2_ready0", a_ready0, 1);
        checkOutput("c2_ram_we", a_ram_we, 1);
        checkOutput("c2_ram_addr", a_ram_addr, 9'h010);
        checkOutput("c2_ram_din", a_ram_din, 8'hA5);
        applyStimulus(0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h5A);            // cycle 3
        checkOutput("c3_ready1", a_ready1, 1);
        checkOutput("c3_ram_we", a_ram_we, 0);
        checkOutput("c3_ram_addr", a_ram_addr, 9'h010);
        checkOutput("c3_a_rvalid0", a_rvalid0, 0);
        applyStimulus(1, 0, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00);            // cycle 4
        checkOutput("c4_ready0", a_ready0, 1);
        checkOutput("c4_a_rvalid0", a_rvalid0, 1);
        checkOutput("c4_a_rdata0", a_rdata0, 8'hA5);
        checkOutput("c4_a_rvalid1", a_rvalid1, 0);
        checkOutput("c4_b_rvalid0", b_rvalid0, 0);
        checkOutput("c4_ram_addr", a_ram_addr, 9'h1FF);
        checkOutput("c4_ram_din", a_ram_din, 8'h5A);
        applyStimulus(0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h3C);            // cycle 5
        checkOutput("c5_a_rvalid", {a_rvalid0, a_rvalid1}, 0);
        checkOutput("c5_b_rvalid0", b_rvalid0, 1);
        checkOutput("c5_b_rdata0", b_rdata0, 8'hA5);
        checkOutput("c5_b_rvalid1", b_rvalid1, 0);

        // Both requesters reading for four cycles; pointer currently favours req0.
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);            // cycle 6
        checkOutput("c6_grant", {a_ready0, a_ready1}, 2'b10);
        checkOutput("c6_a_rvalid0", a_rvalid0, 1);
        checkOutput("c6_a_rdata0", a_rdata0, 8'h5A);
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);            // cycle 7
        checkOutput("c7_grant", {a_ready0, a_ready1}, 2'b01);
        checkOutput("c7_a_rvalid", {a_rvalid0, a_rvalid1}, 0);
        checkOutput("c7_b_rvalid0", b_rvalid0, 1);
        checkOutput("c7_b_rdata0", b_rdata0, 8'h5A);
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);            // cycle 8
        checkOutput("c8_grant", {a_ready0, a_ready1}, 2'b10);
        checkOutput("c8_a_rvalid", {a_rvalid0, a_rvalid1}, 2'b10);
        checkOutput("c8_a_rdata0", a_rdata0, 8'hA5);
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);            // cycle 9
        checkOutput("c9_grant", {a_ready0, a_ready1}, 2'b01);
        checkOutput("c9_a_rvalid", {a_rvalid0, a_rvalid1}, 2'b01);
        checkOutput("c9_a_rdata1", a_rdata1, 8'h3C);
        checkOutput("c9_b_rvalid", {b_rvalid0, b_rvalid1}, 2'b10);
        checkOutput("c9_b_rdata0", b_rdata0, 8'hA5);
        idle();                                                             // cycle 10
        checkOutput("c10_a_rvalid", {a_rvalid0, a_rvalid1}, 2'b10);
        checkOutput("c10_a_rdata0", a_rdata0, 8'hA5);
        checkOutput("c10_b_rvalid", {b_rvalid0, b_rvalid1}, 2'b01);
        checkOutput("c10_b_rdata1", b_rdata1, 8'h3C);
        idle();                                                             // cycle 11
        checkOutput("c11_a_rvalid", {a_rvalid0, a_rvalid1}, 2'b01);
        checkOutput("c11_a_rdata1", a_rdata1, 8'h3C);
        checkOutput("c11_b_rvalid", {b_rvalid0, b_rvalid1}, 2'b10);
        idle();                                                             // cycle 12
        checkOutput("c12_a_rvalid", {a_rvalid0, a_rvalid1}, 2'b00);
        checkOutput("c12_b_rvalid", {b_rvalid0, b_rvalid1}, 2'b01);
        checkOutput("c12_b_rdata1", b_rdata1, 8'h3C);
        idle();                                                             // cycle 13
        checkOutput("c13_b_rvalid", {b_rvalid0, b_rvalid1}, 2'b00);

        // Preload 0x000..0x003 with 0x11..0x44, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 9'(i), 8'((i + 1) * 17), 0, 0, 9'h000, 8'h00);
            checkOutput("pre_ready0", a_ready0, 1);
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) applyStimulus(1, 0, 9'(c), 8'h00, 0, 0, 9'h000, 8'h00);
            else idle();
            checkOutput("b2b_a_rvalid0", a_rvalid0, (c >= 2 && c <= 5) ? 1 : 0);
            if (c >= 2 && c <= 5) checkOutput("b2b_a_rdata0", a_rdata0, 32'((c - 1) * 17));
            checkOutput("b2b_b_rvalid0", b_rvalid0, (c >= 3 && c <= 6) ? 1 : 0);
            if (c >= 3 && c <= 6) checkOutput("b2b_b_rdata0", b_rdata0, 32'((c - 2) * 17));
        end

        // Reset one cycle after a read accept: the read must vanish, pointer returns to req0.
        applyStimulus(1, 0, 9'h010, 8'h00, 0, 0, 9'h000, 8'h00);
        checkOutput("mid_ready0", a_ready0, 1);
        idle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ram_addr", a_ram_addr, 0);
        checkOutput("mid_rst_rvalid", {a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}, 0);
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) rst = 1'b0;
            checkOutput("post_rst_rvalid", {a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}, 0);
        end
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);
        checkOutput("post_rst_grant_a", {a_ready0, a_ready1}, 2'b10);
        checkOutput("post_rst_grant_b", {b_ready0, b_ready1}, 2'b10);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
